// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; serialises loads/stores into little-endian byte accesses
// on an 8-bit req/ack port. Optional macro MEM_LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses.

`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP 8'b11100000
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b11100100
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP 8'b11100001
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b11100101
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP 8'b11100011
`endif
`ifndef EXE_SB_OP
`define EXE_SB_OP 8'b11101000
`endif
`ifndef EXE_SH_OP
`define EXE_SH_OP 8'b11101001
`endif
`ifndef EXE_SW_OP
`define EXE_SW_OP 8'b11101011
`endif

module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`AluOpBus]  aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    input  logic [7:0]        bus_rdata_i,
    input  logic              bus_ack_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq_o
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r, state_n;
    logic [`AluOpBus]  op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       data_r;
    logic [4:0]        wd_r;
    logic [1:0]        idx_r;
    logic [31:0]       asm_r;
    logic              misal_r;
    logic              accept_s;
    logic              take_s;
    logic              trap_s;

    function automatic logic is_mem(input logic [`AluOpBus] op);
        case (op)
            `EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP,
            `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP: is_mem = 1'b1;
            default:                            is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [`AluOpBus] op);
        case (op)
            `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP: is_store = 1'b1;
            default:                            is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [`AluOpBus] op);
        case (op)
            `EXE_LH_OP, `EXE_LHU_OP, `EXE_SH_OP: last_idx = 2'd1;
            `EXE_LW_OP, `EXE_SW_OP:              last_idx = 2'd3;
            default:                             last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [`AluOpBus] op, input logic [31:0] a);
        case (op)
            `EXE_LB_OP:  extend = {{24{a[7]}}, a[7:0]};
            `EXE_LBU_OP: extend = {24'h000000, a[7:0]};
            `EXE_LH_OP:  extend = {{16{a[15]}}, a[15:0]};
            `EXE_LHU_OP: extend = {16'h0000, a[15:0]};
            default:     extend = a;
        endcase
    endfunction

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [`AluOpBus] op, input logic [1:0] lo);
        case (op)
            `EXE_LH_OP, `EXE_LHU_OP, `EXE_SH_OP: misaligned = lo[0];
            `EXE_LW_OP, `EXE_SW_OP:              misaligned = (lo != 2'b00);
            default:                             misaligned = 1'b0;
        endcase
    endfunction
`endif

    // Next-state and output decode; reset forces every output low for that cycle.
    always_comb begin
        state_n     = state_r;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = 8'h00;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'h0000_0000;
        stallreq_o  = 1'b0;
        accept_s    = 1'b0;
        take_s      = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap_s      = misaligned(aluop_i, mem_addr_i[1:0]);
`else
        trap_s      = 1'b0;
`endif
        if (rst) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_mem(aluop_i)) begin
                        accept_s   = 1'b1;
                        stallreq_o = 1'b1;
                        state_n    = trap_s ? ST_DONE : ST_ACCESS;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                ST_ACCESS: begin
                    bus_req_o   = 1'b1;
                    bus_we_o    = is_store(op_r);
                    bus_addr_o  = addr_r + ADDR_W'(idx_r);
                    bus_wdata_o = data_r[{idx_r, 3'b000} +: 8];
                    stallreq_o  = 1'b1;
                    if (bus_ack_i) begin
                        take_s  = 1'b1;
                        state_n = (idx_r == last_idx(op_r)) ? ST_DONE : ST_ACCESS;
                    end else begin
                        state_n = ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                    if (is_store(op_r) || misal_r) begin
                        wreg_o = 1'b0;
                    end else begin
                        wd_o    = wd_r;
                        wreg_o  = 1'b1;
                        wdata_o = extend(op_r, asm_r);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign misalign_o = !rst && (state_r == ST_DONE) && misal_r;
`endif

    // State, latched instruction fields and load-byte assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= '0;
            addr_r  <= '0;
            data_r  <= 32'h0000_0000;
            wd_r    <= 5'd0;
            idx_r   <= 2'd0;
            asm_r   <= 32'h0000_0000;
            misal_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (accept_s) begin
                op_r    <= aluop_i;
                addr_r  <= mem_addr_i;
                data_r  <= reg2_i;
                wd_r    <= wd_i;
                idx_r   <= 2'd0;
                asm_r   <= 32'h0000_0000;
                misal_r <= trap_s;
            end else if (take_s) begin
                idx_r <= idx_r + 2'd1;
                if (!is_store(op_r)) begin
                    asm_r[{idx_r, 3'b000} +: 8] <= bus_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized self-checking bench for mem_lsu with a byte-memory responder
// (configurable ack wait, spurious idle acks) and an instruction-level reference model.
module tb_mem_lsu;

    localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h20;
    localparam logic [7:0] OP_LB  = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3, OP_SB  = 8'hE8, OP_SH = 8'hE9, OP_SW  = 8'hEB;

    logic        clk, rst;
    logic [7:0]  aluop;
    logic [31:0] mem_addr, reg2, wdata_in, bus_addr, wdata_out;
    logic [4:0]  wd_in, wd_out;
    logic        wreg_in, wreg_out, bus_req, bus_we, bus_ack, stallreq;
    logic [7:0]  bus_wdata, bus_rdata;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
        .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
        .wd_o(wd_out), .wreg_o(wreg_out), .wdata_o(wdata_out), .stallreq_o(stallreq)
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        , .misalign_o(misalign)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder memory (written by the DUT) and reference image (written by the model).
    logic [7:0] mem     [4096];
    logic [7:0] ref_mem [4096];
    logic       load_img;

    typedef struct { logic [31:0] addr; logic we; logic [7:0] data; } acc_t;
    acc_t acc_q[$];

    int          ack_delay = 0;
    int          wcnt = 0;
    logic        noise = 1'b0;
    logic        held = 1'b0;
    logic [31:0] h_addr;
    logic        h_we;
    logic [7:0]  h_wdata;

    assign bus_ack   = bus_req ? (wcnt == ack_delay) : noise;
    assign bus_rdata = mem[bus_addr[11:0]];

    always @(posedge clk) begin
        noise <= 1'($urandom_range(0, 1));
        if (held) begin
            chk("hold_req", 32'(bus_req), 32'd1);
            chk("hold_addr", bus_addr, h_addr);
            chk("hold_we", 32'(bus_we), 32'(h_we));
            chk("hold_wdata", 32'(bus_wdata), 32'(h_wdata));
        end
        held    <= bus_req && !bus_ack;
        h_addr  <= bus_addr;
        h_we    <= bus_we;
        h_wdata <= bus_wdata;
        if (load_img) begin
            for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
        end else if (bus_req && bus_ack && bus_we) begin
            mem[bus_addr[11:0]] <= bus_wdata;
        end
        if (bus_req && bus_ack) begin
            acc_q.push_back('{bus_addr, bus_we, bus_wdata});
            wcnt <= 0;
        end else if (bus_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    function automatic int nbytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [7:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction

    function automatic bit is_st(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    // Little-endian value of the bytes from the reference image, then signed narrowing.
    function automatic logic [31:0] load_value(input logic [7:0] op, input logic [31:0] addr);
        int unsigned v = 0;
        for (int i = nbytes(op) - 1; i >= 0; i--) v = v * 256 + 32'(ref_mem[12'(addr + 32'(i))]);
        if (op == OP_LB && v >= 128)   v = v - 256;
        if (op == OP_LH && v >= 32768) v = v - 65536;
        return v;
    endfunction

    logic [31:0] last_wdata;

    task automatic idle_inputs();
        aluop = OP_NOP; wreg_in = 1'b0; wd_in = 5'd0; wdata_in = 32'h0; mem_addr = 32'h0; reg2 = 32'h0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                           input logic [4:0] wd, input int d);
        int   n, base, cyc;
        bit   trap;
        logic [31:0] exp_v;
        acc_t a;
        n    = nbytes(op);
        trap = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap = (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
`endif
        if (trap) n = 0;
        exp_v     = load_value(op, addr);
        base      = acc_q.size();
        ack_delay = d;
        aluop = op; mem_addr = addr; reg2 = r2; wd_in = wd; wreg_in = 1'b1; wdata_in = 32'hDEAD_BEEF;
        cyc = 0;
        @(negedge clk);
        chk("accept_req", 32'(bus_req), 32'd0);
        while (stallreq === 1'b1 && cyc < 100) begin
            chk("stall_wreg", 32'(wreg_out), 32'd0);
            cyc++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(cyc), 32'(1 + n * (d + 1)));
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_wreg", 32'(wreg_out), 32'(is_ld(op) && !trap));
        if (is_ld(op) && !trap) begin
            chk("done_wd", 32'(wd_out), 32'(wd));
            chk("load_data", wdata_out, exp_v);
        end else begin
            chk("done_wdata", wdata_out, 32'h0);
        end
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        chk("misalign", 32'(misalign), 32'(trap));
`endif
        last_wdata = wdata_out;
        @(posedge clk); #1;
        idle_inputs();
        chk("n_access", 32'(acc_q.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < acc_q.size(); i++) begin
            a = acc_q[base + i];
            chk("acc_addr", a.addr, addr + 32'(i));
            chk("acc_we", 32'(a.we), 32'(is_st(op)));
            if (is_st(op)) chk("acc_wdata", 32'(a.data), (r2 >> (8 * i)) & 32'hFF);
        end
        if (is_st(op) && !trap) begin
            for (int i = 0; i < n; i++) ref_mem[12'(addr + 32'(i))] = 8'(r2 >> (8 * i));
        end
    endtask

    task automatic run_alu(input logic [7:0] op, input logic [4:0] wd, input logic wr, input logic [31:0] wv);
        aluop = op; wd_in = wd; wreg_in = wr; wdata_in = wv;
        mem_addr = $urandom(); reg2 = $urandom();
        @(negedge clk);
        chk("alu_wd", 32'(wd_out), 32'(wd));
        chk("alu_wreg", 32'(wreg_out), 32'(wr));
        chk("alu_wdata", wdata_out, wv);
        chk("alu_stall", 32'(stallreq), 32'd0);
        chk("alu_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_we"}, 32'(bus_we), 32'd0);
        chk({tag, "_addr"}, bus_addr, 32'h0);
        chk({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
        chk({tag, "_wd"}, 32'(wd_out), 32'd0);
        chk({tag, "_wreg"}, 32'(wreg_out), 32'd0);
        chk({tag, "_wdo"}, wdata_out, 32'h0);
        chk({tag, "_stall"}, 32'(stallreq), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [7:0] mem_ops [8];
    initial begin
        int diffs, base, r;
        logic [7:0] op;
        logic [31:0] addr;
        mem_ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom());
        ref_mem[12'h100] = 8'h11; ref_mem[12'h101] = 8'h22;
        ref_mem[12'h102] = 8'h33; ref_mem[12'h103] = 8'h44;
        ref_mem[12'h020] = 8'h80;
        rst = 1'b1; load_img = 1'b1;
        aluop = OP_ADD; wd_in = 5'd3; wreg_in = 1'b1; wdata_in = 32'h5; mem_addr = 32'h0; reg2 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0; load_img = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk_all_zero("post_rst");
        @(posedge clk); #1;

        run_mem(OP_LW, 32'h100, 32'h0, 5'd7, 0);
        chk("t1_lw", last_wdata, 32'h4433_2211);
        run_mem(OP_LB, 32'h20, 32'h0, 5'd8, 0);
        chk("t2_lb", last_wdata, 32'hFFFF_FF80);
        run_mem(OP_LBU, 32'h20, 32'h0, 5'd9, 1);
        chk("t2_lbu", last_wdata, 32'h0000_0080);
        run_mem(OP_SH, 32'h41, 32'hABCD_1234, 5'd1, 2);
`ifndef MEM_LSU_MISALIGN_TRAP_EN
        chk("t3_b0", 32'(mem[12'h041]), 32'h34);
        chk("t3_b1", 32'(mem[12'h042]), 32'h12);
`endif
        run_alu(OP_ADD, 5'd3, 1'b1, 32'h5);

        // Reset lands after the second byte of a zero-wait LW has been acked.
        base = acc_q.size();
        ack_delay = 0;
        aluop = OP_LW; mem_addr = 32'h300; wd_in = 5'd4; wreg_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk_all_zero("t5_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("t5_idle");
        chk("t5_n_access", 32'(acc_q.size() - base), 32'd2);
        @(posedge clk); #1;
        run_mem(OP_LB, 32'h20, 32'h0, 5'd5, 0);
        chk("t5_lb", last_wdata, 32'hFFFF_FF80);

        run_mem(OP_LW, 32'hFFFF_FFFE, 32'h0, 5'd6, 0);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                op   = mem_ops[$urandom_range(0, 7)];
                addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : 32'($urandom());
                run_mem(op, addr, $urandom(), 5'($urandom()), $urandom_range(0, 2));
            end else if (r == 7) begin
                run_alu(OP_ADD, 5'($urandom()), 1'($urandom()), $urandom());
            end else begin
                run_alu({1'b0, 7'($urandom())}, 5'($urandom()), 1'($urandom()), $urandom());
            end
        end

        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
